// File: rtl/ex_result_stage.sv
// ex_result_stage
// ---------------
// Back end of the execute stage, sitting directly behind the ALU. It takes the
// ALU result and zero flag together with the decoded side-band of the same
// instruction. It resolves branches and jumps, emits a one-cycle PC redirect
// pulse, and builds the writeback packet. That packet is held in a 2-entry skid
// buffer with a valid/ready handshake toward memory/writeback.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   flush               kills every held entry and any pending redirect
//   in_valid/in_ready   upstream handshake (in_ready depends on state only)
//   alu_result          ALU result
//   alu_result_is_zero  ALU zero flag
//   in_pc, in_imm       instruction PC and sign-extended immediate
//   in_rd, in_reg_write destination register and its write enable
//   in_kind             0 ALU, 1 branch-if-zero, 2 branch-if-nonzero,
//                       3 JAL, 4 JALR, other codes behave as ALU
//   out_valid/out_ready downstream handshake
//   out_rd, out_reg_write, out_wdata, out_misaligned  writeback packet
//   redirect_valid, redirect_pc                       PC redirect pulse
module ex_result_stage #(
   parameter int              XLEN            = 32,
   parameter logic [XLEN-1:0] RESET_PC_UNUSED = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] alu_result,
   input  logic            alu_result_is_zero,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] in_imm,
   input  logic [4:0]      in_rd,
   input  logic            in_reg_write,
   input  logic [2:0]      in_kind,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [4:0]      out_rd,
   output logic            out_reg_write,
   output logic [XLEN-1:0] out_wdata,
   output logic            out_misaligned,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc
);

   typedef enum logic [2:0] {
      KIND_ALU  = 3'd0,
      KIND_BEQZ = 3'd1,
      KIND_BNEZ = 3'd2,
      KIND_JAL  = 3'd3,
      KIND_JALR = 3'd4
   } kind_e;

   typedef struct packed {
      logic [4:0]      rd;
      logic            reg_write;
      logic [XLEN-1:0] wdata;
      logic            misaligned;
   } wb_pkt_t;

   localparam logic [XLEN-1:0] LINK_OFFSET = XLEN'(4);
   localparam logic [XLEN-1:0] JALR_MASK   = {{(XLEN-1){1'b1}}, 1'b0};

   wb_pkt_t         main_pkt;
   wb_pkt_t         skid_pkt;
   logic            main_valid;
   logic            skid_valid;
   wb_pkt_t         new_pkt;
   logic            new_taken;
   logic [XLEN-1:0] new_target;
   logic [XLEN-1:0] link_addr;
   logic            accept;
   logic            drain;

   // The upstream sees ready only from registered state. A full skid entry means
   // there is no room for a packet. A redirect pulse in flight forces a bubble so
   // the wrong-path instruction behind a taken branch is never taken in. Reset
   // gates ready so nothing can slip in while the state is being cleared.
   assign in_ready = !rst && !skid_valid && !redirect_valid;
   assign accept   = in_valid && in_ready && !flush;
   assign drain    = main_valid && out_ready;

   // Per-packet decode: work out the branch/jump outcome, its target and the
   // writeback data. Branches never write a register. Writes to x0 are dropped
   // here so the buffer never carries a write enable for register 0.
   always_comb begin
      link_addr            = in_pc + LINK_OFFSET;
      new_taken            = 1'b0;
      new_target           = in_pc + in_imm;
      new_pkt.rd           = in_rd;
      new_pkt.reg_write    = in_reg_write;
      new_pkt.wdata        = alu_result;
      new_pkt.misaligned   = 1'b0;
      case (kind_e'(in_kind))
         KIND_BEQZ: begin
            new_taken         = alu_result_is_zero;
            new_pkt.reg_write = 1'b0;
         end
         KIND_BNEZ: begin
            new_taken         = !alu_result_is_zero;
            new_pkt.reg_write = 1'b0;
         end
         KIND_JAL: begin
            new_taken     = 1'b1;
            new_pkt.wdata = link_addr;
         end
         KIND_JALR: begin
            new_taken     = 1'b1;
            new_target    = alu_result & JALR_MASK;
            new_pkt.wdata = link_addr;
         end
         default: begin
         end
      endcase
      if (in_rd == 5'd0) begin
         new_pkt.reg_write = 1'b0;
      end
      new_pkt.misaligned = new_taken && new_target[1];
   end

   // Two-entry skid buffer. Main is the output register and skid is the overflow
   // entry. A new packet goes into main whenever main is empty or being drained
   // this edge with nothing waiting in skid. Otherwise it parks in skid. When
   // main drains while skid is occupied, skid moves forward. That case cannot
   // coincide with an accept, because in_ready is low whenever skid is full.
   always_ff @(posedge clk) begin
      if (rst) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         main_pkt   <= '0;
         skid_pkt   <= '0;
      end else if (flush) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else if (drain) begin
         if (skid_valid) begin
            main_pkt   <= skid_pkt;
            skid_valid <= 1'b0;
         end else begin
            main_valid <= accept;
            if (accept) begin
               main_pkt <= new_pkt;
            end
         end
      end else if (!main_valid) begin
         main_valid <= accept;
         if (accept) begin
            main_pkt <= new_pkt;
         end
      end else if (accept) begin
         skid_pkt   <= new_pkt;
         skid_valid <= 1'b1;
      end
   end

   // The redirect pulse follows a taken accept by one cycle and lasts exactly one
   // cycle, whether or not the packet can leave the buffer. The target register
   // keeps its last value between pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         redirect_valid <= 1'b0;
         redirect_pc    <= RESET_PC_UNUSED;
      end else if (flush) begin
         redirect_valid <= 1'b0;
      end else begin
         redirect_valid <= accept && new_taken;
         if (accept && new_taken) begin
            redirect_pc <= new_target;
         end
      end
   end

   // Output fields are masked while main is empty, so an idle stage always shows
   // clean values rather than a stale packet.
   always_comb begin
      out_valid      = main_valid;
      out_rd         = main_valid ? main_pkt.rd : 5'd0;
      out_reg_write  = main_valid && main_pkt.reg_write;
      out_wdata      = main_valid ? main_pkt.wdata : RESET_PC_UNUSED;
      out_misaligned = main_valid && main_pkt.misaligned;
   end

endmodule

// File: tb/tb_ex_result_stage.sv
// tb_ex_result_stage
// ------------------
// Directed bench for ex_result_stage. Stimulus pushes hand-computed writeback
// packets and redirect targets into queues. A monitor on the falling edge pops
// and compares them whenever the DUT presents a packet or a redirect pulse.
module tb_ex_result_stage;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] alu_result;
   logic        alu_result_is_zero;
   logic [31:0] in_pc;
   logic [31:0] in_imm;
   logic [4:0]  in_rd;
   logic        in_reg_write;
   logic [2:0]  in_kind;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  out_rd;
   logic        out_reg_write;
   logic [31:0] out_wdata;
   logic        out_misaligned;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   typedef struct {
      logic [4:0]  rd;
      logic        rw;
      logic [31:0] wdata;
      logic        chk_w;
      logic        mis;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] redir_q[$];
   int          checks = 0;
   int          errors = 0;

   ex_result_stage #(.XLEN(32), .RESET_PC_UNUSED(32'h0)) dut (
      .clk                (clk),
      .rst                (rst),
      .flush              (flush),
      .in_valid           (in_valid),
      .in_ready           (in_ready),
      .alu_result         (alu_result),
      .alu_result_is_zero (alu_result_is_zero),
      .in_pc              (in_pc),
      .in_imm             (in_imm),
      .in_rd              (in_rd),
      .in_reg_write       (in_reg_write),
      .in_kind            (in_kind),
      .out_valid          (out_valid),
      .out_ready          (out_ready),
      .out_rd             (out_rd),
      .out_reg_write      (out_reg_write),
      .out_wdata          (out_wdata),
      .out_misaligned     (out_misaligned),
      .redirect_valid     (redirect_valid),
      .redirect_pc        (redirect_pc)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Global safety net so the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired at %0t", $time);
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%08h expected=0x%08h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      checkOutput({tag, "_redirect_valid"}, 32'(redirect_valid), 32'd0);
      checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd0);
      checkOutput({tag, "_out_wdata"}, out_wdata, 32'h0);
      checkOutput({tag, "_redirect_pc"}, redirect_pc, 32'h0);
      checkOutput({tag, "_out_rd"}, 32'(out_rd), 32'd0);
      checkOutput({tag, "_out_reg_write"}, 32'(out_reg_write), 32'd0);
      checkOutput({tag, "_out_misaligned"}, 32'(out_misaligned), 32'd0);
   endtask

   // Present one packet and hold it until accepted, with a bounded wait. On accept
   // the expected writeback packet and/or redirect target are queued. in_valid is
   // left high so consecutive calls can be issued back to back.
   task automatic applyStimulus(
      input logic [2:0]  kind,   input logic [31:0] res,   input logic z,
      input logic [31:0] pc,     input logic [31:0] imm,   input logic [4:0] rd,
      input logic        rw,     input logic [31:0] e_wdata, input logic e_chkw,
      input logic        e_rw,   input logic e_mis,       input logic e_redir,
      input logic [31:0] e_rpc,  input logic push_out,    input logic push_redir);
      exp_t e;
      bit   got;
      got                = 1'b0;
      in_valid           = 1'b1;
      in_kind            = kind;
      alu_result         = res;
      alu_result_is_zero = z;
      in_pc              = pc;
      in_imm             = imm;
      in_rd              = rd;
      in_reg_write       = rw;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         checks++;
         errors++;
         $display("[TB] FAIL accept_timeout in_ready=0 expected=1 at %0t", $time);
      end else begin
         @(posedge clk);
         if (push_out) begin
            e.rd    = rd;
            e.rw    = e_rw;
            e.wdata = e_wdata;
            e.chk_w = e_chkw;
            e.mis   = e_mis;
            exp_q.push_back(e);
         end
         if (push_redir && e_redir) begin
            redir_q.push_back(e_rpc);
         end
         #1;
      end
   endtask

   // Monitor: pop and compare whenever a packet leaves or a redirect pulses.
   always @(negedge clk) begin
      exp_t        m;
      logic [31:0] rpc;
      if (!rst) begin
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_out wdata=0x%08h rd=%0d expected=none at %0t", out_wdata, out_rd, $time);
            end else begin
               m = exp_q.pop_front();
               checkOutput("sb_out_rd", 32'(out_rd), 32'(m.rd));
               checkOutput("sb_out_reg_write", 32'(out_reg_write), 32'(m.rw));
               checkOutput("sb_out_misaligned", 32'(out_misaligned), 32'(m.mis));
               if (m.chk_w) begin
                  checkOutput("sb_out_wdata", out_wdata, m.wdata);
               end
            end
         end
         if (redirect_valid) begin
            if (redir_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_redirect pc=0x%08h expected=none at %0t", redirect_pc, $time);
            end else begin
               rpc = redir_q.pop_front();
               checkOutput("sb_redirect_pc", redirect_pc, rpc);
            end
         end
      end
   end

   initial begin
      rst                = 1'b1;
      flush              = 1'b0;
      in_valid           = 1'b0;
      alu_result         = '0;
      alu_result_is_zero = 1'b0;
      in_pc              = '0;
      in_imm             = '0;
      in_rd              = '0;
      in_reg_write       = 1'b0;
      in_kind            = '0;
      out_ready          = 1'b1;

      // Reset state.
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkIdle("reset");
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("ready_after_reset", 32'(in_ready), 32'd1);

      // Plain ALU op, one-cycle latency.
      @(posedge clk);
      #1;
      applyStimulus(3'd0, 32'h1234, 1'b0, 32'h0, 32'h0, 5'd5, 1'b1,
                    32'h1234, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      in_valid = 1'b0;
      @(negedge clk);
      checkOutput("alu_latency_valid", 32'(out_valid), 32'd1);
      checkOutput("alu_no_redirect", 32'(redirect_valid), 32'd0);

      // Branch-if-zero taken: negative immediate, one-cycle pulse with a bubble.
      @(posedge clk);
      #1;
      applyStimulus(3'd1, 32'h0, 1'b1, 32'h100, 32'hFFFF_FFF0, 5'd7, 1'b1,
                    32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_00F0, 1'b1, 1'b1);
      in_valid = 1'b0;
      @(negedge clk);
      checkOutput("beqz_redirect_valid", 32'(redirect_valid), 32'd1);
      checkOutput("beqz_bubble_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      checkOutput("beqz_pulse_one_cycle", 32'(redirect_valid), 32'd0);

      // Branch-if-zero not taken.
      @(posedge clk);
      #1;
      applyStimulus(3'd1, 32'h5, 1'b0, 32'h100, 32'hFFFF_FFF0, 5'd7, 1'b1,
                    32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      in_valid = 1'b0;
      @(negedge clk);
      checkOutput("beqz_nt_no_redirect", 32'(redirect_valid), 32'd0);
      checkOutput("beqz_nt_ready", 32'(in_ready), 32'd1);

      // Back-to-back with out_ready high: misaligned bnez, JALR, JAL to x0,
      // unknown kind as ALU, JAL with PC wraparound.
      @(posedge clk);
      #1;
      applyStimulus(3'd2, 32'h1, 1'b0, 32'h200, 32'h12, 5'd4, 1'b1,
                    32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h212, 1'b1, 1'b1);
      applyStimulus(3'd4, 32'h2003, 1'b0, 32'h40, 32'h0, 5'd1, 1'b1,
                    32'h44, 1'b1, 1'b1, 1'b1, 1'b1, 32'h2002, 1'b1, 1'b1);
      applyStimulus(3'd3, 32'h0, 1'b0, 32'h300, 32'h20, 5'd0, 1'b1,
                    32'h304, 1'b1, 1'b0, 1'b0, 1'b1, 32'h320, 1'b1, 1'b1);
      applyStimulus(3'd5, 32'hABCD, 1'b0, 32'h0, 32'h0, 5'd3, 1'b1,
                    32'hABCD, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      applyStimulus(3'd3, 32'h0, 1'b0, 32'hFFFF_FFFC, 32'h8, 5'd2, 1'b1,
                    32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h4, 1'b1, 1'b1);
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // Backpressure: A to main, B to skid, C stalled; release drains in order.
      out_ready = 1'b0;
      fork
         begin
            applyStimulus(3'd0, 32'hA, 1'b0, 32'h0, 32'h0, 5'd10, 1'b1,
                          32'hA, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
            applyStimulus(3'd0, 32'hB, 1'b0, 32'h0, 32'h0, 5'd11, 1'b1,
                          32'hB, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
            applyStimulus(3'd0, 32'hC, 1'b0, 32'h0, 32'h0, 5'd12, 1'b1,
                          32'hC, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
            in_valid = 1'b0;
         end
         begin
            repeat (4) @(negedge clk);
            checkOutput("skid_full_ready", 32'(in_ready), 32'd0);
            checkOutput("skid_main_valid", 32'(out_valid), 32'd1);
            checkOutput("skid_main_stable", out_wdata, 32'hA);
            @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      repeat (3) @(posedge clk);
      #1;

      // Flush with main and skid full and a redirect pulse showing.
      out_ready = 1'b0;
      applyStimulus(3'd0, 32'h11, 1'b0, 32'h0, 32'h0, 5'd9, 1'b1,
                    32'h11, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      applyStimulus(3'd3, 32'h0, 1'b0, 32'h500, 32'h40, 5'd9, 1'b1,
                    32'h504, 1'b1, 1'b1, 1'b0, 1'b1, 32'h540, 1'b0, 1'b1);
      alu_result = 32'hDEAD;
      in_kind    = 3'd0;
      flush      = 1'b1;
      @(negedge clk);
      checkOutput("preflush_redirect", 32'(redirect_valid), 32'd1);
      checkOutput("preflush_out_valid", 32'(out_valid), 32'd1);
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
      checkOutput("flush_redirect", 32'(redirect_valid), 32'd0);
      checkOutput("flush_in_ready", 32'(in_ready), 32'd1);

      // A packet offered during a flush cycle is dropped even though ready is high.
      @(posedge clk);
      #1;
      in_valid   = 1'b1;
      in_kind    = 3'd0;
      alu_result = 32'hBEEF;
      in_rd      = 5'd6;
      flush      = 1'b1;
      @(negedge clk);
      checkOutput("flush_drop_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      checkOutput("flush_drop_out_valid", 32'(out_valid), 32'd0);
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      // Reset asserted mid-stream with a packet and a redirect in flight.
      out_ready = 1'b0;
      applyStimulus(3'd3, 32'h0, 1'b0, 32'h600, 32'h10, 5'd8, 1'b1,
                    32'h604, 1'b1, 1'b1, 1'b0, 1'b1, 32'h610, 1'b0, 1'b0);
      in_valid = 1'b0;
      rst      = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkIdle("midrst");
      @(posedge clk);
      #1;
      rst       = 1'b0;
      out_ready = 1'b1;

      repeat (5) @(posedge clk);
      @(negedge clk);
      checkOutput("scoreboard_empty", 32'(exp_q.size() + redir_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
